// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the register-file read stage, alu_pipe and writeback.
interface alu_pipe_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] operandA;
   logic [WIDTH-1:0] operandB;
   logic [2:0]       command;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carryout;
   logic             zero;
   logic             overflow;
   logic             clr_sticky;
   logic             ovf_sticky;

   // Producer/consumer side: drives operands and accepts results.
   modport master (
      output in_valid, operandA, operandB, command, out_ready, clr_sticky,
      input  in_ready, out_valid, result, carryout, zero, overflow, ovf_sticky
   );

   // ALU side.
   modport slave (
      input  in_valid, operandA, operandB, command, out_ready, clr_sticky,
      output in_ready, out_valid, result, carryout, zero, overflow, ovf_sticky
   );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU (operand stage, result stage) with valid/ready on both sides
// and a sticky signed-overflow status bit.
module alu_pipe #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          STICKY_EN = 1'b1
) (
   input logic       clk,
   input logic       reset,
   alu_pipe_if.slave bus
);
   localparam int unsigned MSB = WIDTH - 1;
   localparam int unsigned SW  = WIDTH + 1;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_SLT  = 3'd3;
   localparam logic [2:0] OP_CNE  = 3'd4;
   localparam logic [2:0] OP_AND  = 3'd5;
   localparam logic [2:0] OP_OR   = 3'd6;
   localparam logic [2:0] OP_SLTU = 3'd7;

   // Stage 1: captured operands and command.
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [2:0]       s1_cmd_q, s1_cmd_d;

   // Stage 2: registered results driving the outputs.
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             sticky_q, sticky_d;

   logic             s2_load_c;
   logic             in_ready_c;
   logic             in_xfer_c;
   logic             out_xfer_c;

   logic [WIDTH-1:0] b_eff_c;
   logic [SW-1:0]    sum_c;
   logic [WIDTH-1:0] alu_res_c;
   logic             alu_cy_c;
   logic             alu_ov_c;

   // Handshake: s2 advances when it is empty or being drained; s1 frees up when s2 loads.
   assign s2_load_c  = s1_valid_q && (!out_valid_q || bus.out_ready);
   assign in_ready_c = !s1_valid_q || s2_load_c;
   assign in_xfer_c  = bus.in_valid && in_ready_c;
   assign out_xfer_c = out_valid_q && bus.out_ready;

   // Combinational ALU on the stage-1 operands; SUB shares the adder as A + ~B + 1.
   always_comb begin
      alu_res_c = '0;
      alu_cy_c  = 1'b0;
      alu_ov_c  = 1'b0;
      b_eff_c   = (s1_cmd_q == OP_SUB) ? ~s1_b_q : s1_b_q;
      sum_c     = SW'(s1_a_q) + SW'(b_eff_c) + SW'(s1_cmd_q == OP_SUB);
      case (s1_cmd_q)
         OP_ADD, OP_SUB: begin
            alu_res_c = sum_c[MSB:0];
            alu_cy_c  = sum_c[WIDTH];
            alu_ov_c  = (s1_a_q[MSB] == b_eff_c[MSB]) && (sum_c[MSB] != s1_a_q[MSB]);
         end
         OP_XOR:  alu_res_c = s1_a_q ^ s1_b_q;
         OP_SLT:  alu_res_c = {{(WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
         OP_CNE:  alu_res_c = {{(WIDTH-1){1'b0}}, (s1_a_q != s1_b_q)};
         OP_AND:  alu_res_c = s1_a_q & s1_b_q;
         OP_OR:   alu_res_c = s1_a_q | s1_b_q;
         OP_SLTU: alu_res_c = {{(WIDTH-1){1'b0}}, (s1_a_q < s1_b_q)};
         default: alu_res_c = '0;
      endcase
   end

   // Next-state for both stages and the sticky bit; set beats clear on the same cycle.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_cmd_d    = s1_cmd_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      sticky_d    = sticky_q;

      if (in_xfer_c) begin
         s1_valid_d = 1'b1;
         s1_a_d     = bus.operandA;
         s1_b_d     = bus.operandB;
         s1_cmd_d   = bus.command;
      end else if (s2_load_c) begin
         s1_valid_d = 1'b0;
      end

      if (s2_load_c) begin
         out_valid_d = 1'b1;
         result_d    = alu_res_c;
         carry_d     = alu_cy_c;
         zero_d      = (alu_res_c == '0);
         ovf_d       = alu_ov_c;
      end else if (out_xfer_c) begin
         out_valid_d = 1'b0;
      end

      sticky_d = STICKY_EN ? ((sticky_q && !bus.clr_sticky) || (out_xfer_c && ovf_q)) : 1'b0;
   end

   // State registers; reset discards anything in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_cmd_q    <= 3'd0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_cmd_q    <= s1_cmd_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         sticky_q    <= sticky_d;
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = out_valid_q;
   assign bus.result     = result_q;
   assign bus.carryout   = carry_q;
   assign bus.zero       = zero_q;
   assign bus.overflow   = ovf_q;
   assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a 32-bit instance with sticky enabled and an 8-bit one without.
module tb_alu_pipe;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(32)) bus32 ();
   alu_pipe_if #(.WIDTH(8))  bus8 ();

   alu_pipe #(.WIDTH(32), .STICKY_EN(1'b1)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
   alu_pipe #(.WIDTH(8),  .STICKY_EN(1'b0)) dut8  (.clk(clk), .reset(reset), .bus(bus8));

   typedef struct packed {
      logic [2:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        cy;
      logic        z;
      logic        ov;
   } vec_t;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One op through an idle pipe with out_ready high; reports outputs and cycles to out_valid.
   task automatic run_op(input bit w8, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r, output logic cy,
                         output logic z, output logic ov, output int lat);
      if (w8) begin
         bus8.out_ready = 1'b1; bus8.in_valid = 1'b1; bus8.command = c;
         bus8.operandA = a[7:0]; bus8.operandB = b[7:0];
      end else begin
         bus32.out_ready = 1'b1; bus32.in_valid = 1'b1; bus32.command = c;
         bus32.operandA = a; bus32.operandB = b;
      end
      tick;
      bus8.in_valid  = 1'b0;
      bus32.in_valid = 1'b0;
      lat = 1;
      while (((w8 ? bus8.out_valid : bus32.out_valid) !== 1'b1) && lat < 8) begin
         tick;
         lat++;
      end
      r  = w8 ? {24'h0, bus8.result} : bus32.result;
      cy = w8 ? bus8.carryout : bus32.carryout;
      z  = w8 ? bus8.zero : bus32.zero;
      ov = w8 ? bus8.overflow : bus32.overflow;
      tick;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.clr_sticky = 1'b0;
      bus32.operandA = '0; bus32.operandB = '0; bus32.command = 3'd0;
      bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.clr_sticky = 1'b0;
      bus8.operandA = '0; bus8.operandB = '0; bus8.command = 3'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      tick;
      total++;
      if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_hs32 in_ready=%b out_valid=%b want 1 0", bus32.in_ready, bus32.out_valid);
      end
      total++;
      if (bus32.result !== 32'h0 ||
          {bus32.carryout, bus32.zero, bus32.overflow, bus32.ovf_sticky} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_data32 result=%h flags=%b want 0 0000", bus32.result,
                  {bus32.carryout, bus32.zero, bus32.overflow, bus32.ovf_sticky});
      end
      total++;
      if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.result !== 8'h0) begin
         bad++;
         $display("FAIL reset_8 in_ready=%b out_valid=%b result=%h want 1 0 00",
                  bus8.in_ready, bus8.out_valid, bus8.result);
      end
   endtask

   task automatic test_add_ovf;
      logic [31:0] r; logic cy, z, ov; int lat;
      run_op(1'b0, 3'd0, 32'h7FFF_FFFF, 32'h1, r, cy, z, ov, lat);
      total++;
      if (lat != 2) begin
         bad++; $display("FAIL add_latency got=%0d want=2", lat);
      end
      total++;
      if ({r, cy, z, ov} !== {32'h8000_0000, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL add_ovf res=%h cy=%b z=%b ov=%b want 80000000 0 0 1", r, cy, z, ov);
      end
      total++;
      if (bus32.ovf_sticky !== 1'b1) begin
         bad++; $display("FAIL add_sticky_set got=%b want=1", bus32.ovf_sticky);
      end
      bus32.clr_sticky = 1'b1;
      tick;
      bus32.clr_sticky = 1'b0;
      total++;
      if (bus32.ovf_sticky !== 1'b0) begin
         bad++; $display("FAIL add_sticky_clr got=%b want=0", bus32.ovf_sticky);
      end
   endtask

   task automatic test_sub_cmp;
      logic [31:0] r; logic cy, z, ov; int lat;
      vec_t vq[$];
      vq.push_back('{3'd1, 32'd5,          32'd5,          32'h0000_0000, 1'b1, 1'b1, 1'b0});
      vq.push_back('{3'd1, 32'd3,          32'd5,          32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
      vq.push_back('{3'd1, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1});
      vq.push_back('{3'd0, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b1, 1'b1, 1'b0});
      vq.push_back('{3'd3, 32'h8000_0000,  32'd1,          32'h0000_0001, 1'b0, 1'b0, 1'b0});
      vq.push_back('{3'd3, 32'h7FFF_FFFF,  32'h8000_0000,  32'h0000_0000, 1'b0, 1'b1, 1'b0});
      vq.push_back('{3'd7, 32'h8000_0000,  32'd1,          32'h0000_0000, 1'b0, 1'b1, 1'b0});
      vq.push_back('{3'd7, 32'd1,          32'h8000_0000,  32'h0000_0001, 1'b0, 1'b0, 1'b0});
      vq.push_back('{3'd4, 32'h1234,       32'h1234,       32'h0000_0000, 1'b0, 1'b1, 1'b0});
      vq.push_back('{3'd4, 32'h1234,       32'h1235,       32'h0000_0001, 1'b0, 1'b0, 1'b0});
      for (int i = 0; i < vq.size(); i++) begin
         run_op(1'b0, vq[i].c, vq[i].a, vq[i].b, r, cy, z, ov, lat);
         total++;
         if ({r, cy, z, ov} !== {vq[i].r, vq[i].cy, vq[i].z, vq[i].ov} || lat != 2) begin
            bad++;
            $display("FAIL sub_cmp[%0d] got res=%h cy=%b z=%b ov=%b lat=%0d want res=%h cy=%b z=%b ov=%b lat=2",
                     i, r, cy, z, ov, lat, vq[i].r, vq[i].cy, vq[i].z, vq[i].ov);
         end
      end
   endtask

   task automatic test_logic;
      logic [31:0] r; logic cy, z, ov; int lat;
      vec_t vq[$];
      vq.push_back('{3'd5, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b0, 1'b1, 1'b0});
      vq.push_back('{3'd6, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
      vq.push_back('{3'd2, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0});
      vq.push_back('{3'd2, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 1'b1, 1'b0});
      for (int i = 0; i < vq.size(); i++) begin
         run_op(1'b0, vq[i].c, vq[i].a, vq[i].b, r, cy, z, ov, lat);
         total++;
         if ({r, cy, z, ov} !== {vq[i].r, vq[i].cy, vq[i].z, vq[i].ov} || lat != 2) begin
            bad++;
            $display("FAIL logic[%0d] got res=%h cy=%b z=%b ov=%b lat=%0d want res=%h cy=%b z=%b ov=%b lat=2",
                     i, r, cy, z, ov, lat, vq[i].r, vq[i].cy, vq[i].z, vq[i].ov);
         end
      end
   endtask

   task automatic test_back_to_back;
      int          idx = 1;
      logic        rdy, vld;
      logic [31:0] got[$];
      int          cyc[$];
      bus32.out_ready = 1'b0;
      bus32.command   = 3'd0;
      for (int k = 0; k < 6; k++) begin
         vld = (idx <= 4);
         bus32.in_valid = vld;
         bus32.operandA = 32'(idx);
         bus32.operandB = 32'(idx);
         #1;
         rdy = bus32.in_ready;
         if (k >= 2) begin
            total++;
            if (rdy !== 1'b0 || bus32.out_valid !== 1'b1 || bus32.result !== 32'd2) begin
               bad++;
               $display("FAIL stall[%0d] in_ready=%b out_valid=%b result=%h want 0 1 00000002",
                        k, rdy, bus32.out_valid, bus32.result);
            end
         end
         tick;
         if (rdy && vld) idx++;
      end
      total++;
      if (idx != 3) begin
         bad++; $display("FAIL stall_accepted got=%0d want=2", idx - 1);
      end
      bus32.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         vld = (idx <= 4);
         bus32.in_valid = vld;
         bus32.operandA = 32'(idx);
         bus32.operandB = 32'(idx);
         #1;
         rdy = bus32.in_ready;
         if (bus32.out_valid === 1'b1) begin
            got.push_back(bus32.result);
            cyc.push_back(k);
         end
         tick;
         if (rdy && vld) idx++;
      end
      bus32.in_valid = 1'b0;
      total++;
      if (got.size() != 4 || idx != 5) begin
         bad++; $display("FAIL drain_count got=%0d accepted=%0d want 4 4", got.size(), idx - 1);
      end
      for (int i = 0; i < got.size() && i < 4; i++) begin
         total++;
         if (got[i] !== 32'(2 * (i + 1)) || cyc[i] != i) begin
            bad++;
            $display("FAIL drain[%0d] result=%h cycle=%0d want %h %0d", i, got[i], cyc[i], 32'(2 * (i + 1)), i);
         end
      end
   endtask

   task automatic test_sticky;
      bus32.clr_sticky = 1'b1;
      tick;
      bus32.clr_sticky = 1'b0;
      bus32.out_ready  = 1'b0;
      bus32.command    = 3'd0;
      bus32.operandA   = 32'h7FFF_FFFF;
      bus32.operandB   = 32'h1;
      bus32.in_valid   = 1'b1;
      tick;
      bus32.in_valid = 1'b0;
      repeat (4) tick;
      total++;
      if (bus32.out_valid !== 1'b1 || bus32.overflow !== 1'b1 || bus32.ovf_sticky !== 1'b0) begin
         bad++;
         $display("FAIL sticky_held out_valid=%b overflow=%b sticky=%b want 1 1 0",
                  bus32.out_valid, bus32.overflow, bus32.ovf_sticky);
      end
      bus32.out_ready  = 1'b1;
      bus32.clr_sticky = 1'b1;
      tick;
      total++;
      if (bus32.ovf_sticky !== 1'b1 || bus32.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL sticky_set_wins sticky=%b out_valid=%b want 1 0", bus32.ovf_sticky, bus32.out_valid);
      end
      tick;
      bus32.clr_sticky = 1'b0;
      total++;
      if (bus32.ovf_sticky !== 1'b0) begin
         bad++; $display("FAIL sticky_clear got=%b want=0", bus32.ovf_sticky);
      end
   endtask

   task automatic test_reset_mid_stall;
      logic [31:0] r; logic cy, z, ov; int lat;
      bus32.out_ready = 1'b0;
      bus32.command   = 3'd0;
      bus32.operandA  = 32'h7FFF_FFFF;
      bus32.operandB  = 32'h1;
      bus32.in_valid  = 1'b1;
      tick;
      bus32.command  = 3'd1;
      bus32.operandA = 32'd9;
      bus32.operandB = 32'd4;
      tick;
      bus32.in_valid = 1'b0;
      total++;
      if (bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1 || bus32.overflow !== 1'b1) begin
         bad++;
         $display("FAIL mid_stall_fill in_ready=%b out_valid=%b overflow=%b want 0 1 1",
                  bus32.in_ready, bus32.out_valid, bus32.overflow);
      end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (bus32.out_valid !== 1'b0 || bus32.result !== 32'h0 ||
          {bus32.carryout, bus32.zero, bus32.overflow, bus32.ovf_sticky} !== 4'b0000) begin
         bad++;
         $display("FAIL async_reset out_valid=%b result=%h flags=%b want 0 0 0000", bus32.out_valid,
                  bus32.result, {bus32.carryout, bus32.zero, bus32.overflow, bus32.ovf_sticky});
      end
      @(negedge clk);
      reset = 1'b0;
      bus32.out_ready = 1'b1;
      tick;
      total++;
      if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL post_reset in_ready=%b out_valid=%b want 1 0", bus32.in_ready, bus32.out_valid);
      end
      run_op(1'b0, 3'd0, 32'd2, 32'd3, r, cy, z, ov, lat);
      total++;
      if ({r, cy, z, ov} !== {32'd5, 1'b0, 1'b0, 1'b0} || lat != 2) begin
         bad++;
         $display("FAIL post_reset_op res=%h cy=%b z=%b ov=%b lat=%0d want 00000005 0 0 0 2", r, cy, z, ov, lat);
      end
   endtask

   task automatic test_width8;
      logic [31:0] r; logic cy, z, ov; int lat;
      vec_t vq[$];
      vq.push_back('{3'd0, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b0, 1'b1});
      vq.push_back('{3'd0, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b1, 1'b0});
      vq.push_back('{3'd1, 32'h05, 32'h05, 32'h00, 1'b1, 1'b1, 1'b0});
      vq.push_back('{3'd1, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b0, 1'b1});
      vq.push_back('{3'd3, 32'h80, 32'h01, 32'h01, 1'b0, 1'b0, 1'b0});
      vq.push_back('{3'd3, 32'h7F, 32'h80, 32'h00, 1'b0, 1'b1, 1'b0});
      vq.push_back('{3'd7, 32'h80, 32'h01, 32'h00, 1'b0, 1'b1, 1'b0});
      for (int i = 0; i < vq.size(); i++) begin
         run_op(1'b1, vq[i].c, vq[i].a, vq[i].b, r, cy, z, ov, lat);
         total++;
         if ({r, cy, z, ov} !== {vq[i].r, vq[i].cy, vq[i].z, vq[i].ov} || lat != 2) begin
            bad++;
            $display("FAIL w8[%0d] got res=%h cy=%b z=%b ov=%b lat=%0d want res=%h cy=%b z=%b ov=%b lat=2",
                     i, r, cy, z, ov, lat, vq[i].r, vq[i].cy, vq[i].z, vq[i].ov);
         end
      end
      total++;
      if (bus8.ovf_sticky !== 1'b0) begin
         bad++; $display("FAIL w8_sticky_disabled got=%b want=0", bus8.ovf_sticky);
      end
   endtask

   initial begin
      test_reset();
      test_add_ovf();
      test_sub_cmp();
      test_logic();
      test_back_to_back();
      test_sticky();
      test_reset_mid_stall();
      test_width8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish by %0t", $time);
      $fatal(1);
   end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle 32-bit datapath ALU.
- Adds valid/ready handshaking on input and output, plus a two-stage registered datapath of operand stage then result stage.
- Widens the opcode set to eight operations and makes the zero flag valid for every operation.
- Keeps a sticky overflow status register.
- Sits between the register-file read stage and writeback of the multi-cycle CPU.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values are 8 and above.
- STICKY_EN, 1, 1 instantiates the sticky overflow register; 0 ties ovf_sticky to 0.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  operands and command are presented.
- in_ready  output  1  block can accept; a transfer occurs when in_valid && in_ready.
- operandA  input  WIDTH  first operand.
- operandB  input  WIDTH  second operand.
- command  input  3  operation select.
- out_valid  output  1  result stage holds a valid result.
- out_ready  input  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- result  output  WIDTH  registered result.
- carryout  output  1  registered carry.
- zero  output  1  registered zero flag.
- overflow  output  1  registered signed overflow.
- clr_sticky  input  1  synchronous clear of ovf_sticky.
- ovf_sticky  output  1  set once any ADD/SUB overflow result is delivered.

Behaviour:
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A-B, computed as A+~B+1.
  - 2 XOR.
  - 3 SLT: signed A<B.
  - 4 CNE: A!=B.
  - 5 AND.
  - 6 OR.
  - 7 SLTU: unsigned A<B.
- SLT, CNE and SLTU produce result = {WIDTH-1 zeros, bit}.
- SLT is a true signed compare and is correct even when A-B overflows.
- ADD carryout is the carry out of the MSB.
- SUB carryout is 1 iff A>=B unsigned (no borrow).
- overflow is the signed overflow of ADD/SUB. For all other ops, carryout = 0 and overflow = 0.
- zero = (result == 0) for every opcode, including logic ops and compares.
- Stage 1 (s1) captures operandA, operandB and command on an input transfer, and holds s1_valid.
- Stage 2 (s2) captures the computed result, carryout, zero and overflow from s1 when s1 advances. Outputs are driven directly from s2 registers.
- s2 loads when s1_valid && (!out_valid || out_ready). out_valid is cleared by an output transfer unless s2 reloads in the same cycle.
- in_ready = !s1_valid || s2 loads this cycle. in_ready is combinational from out_ready and internal state, with no combinational path from in_valid.
- Latency is exactly 2 cycles from input transfer to out_valid when out_ready is held high.
- Throughput is 1 op/cycle, with no bubbles under continuous valid/ready.
- Backpressure: with out_ready low, at most 2 ops are held (s1 and s2). in_ready falls only when both are full. No op is dropped or duplicated, and s2 outputs are stable while out_valid && !out_ready.
- Ops are delivered in order.
- Sticky overflow register:
  - Sets on an output transfer of an ADD/SUB with overflow = 1.
  - clr_sticky clears it.
  - When clr_sticky coincides with a setting transfer, set wins.
  - Not affected by stalls; a result held under backpressure is not counted until it is transferred.
- Reset (asynchronous, any time including mid-stall):
  - s1_valid = 0, out_valid = 0, result = 0, carryout = 0, zero = 0, overflow = 0, ovf_sticky = 0.
  - in_ready reads 1 on the first cycle after release.
  - Ops in flight are discarded.
- Command and operands are ignored when in_valid = 0. Data registers may hold stale values, but out_valid is the only qualifier.

Test Plan:
- Reset then single ADD, WIDTH=32: A=0x7FFFFFFF, B=1, out_ready=1 -> out_valid exactly 2 cycles after transfer; result=0x80000000, overflow=1, carryout=0, zero=0; ovf_sticky=1 the cycle after the output transfer.
- SUB and compares: A=5, B=5 SUB -> result=0, zero=1, carryout=1. A=0x80000000, B=1 SLT -> result=1; SLTU -> result=0, zero=1. CNE A=B=0x1234 -> result=0, zero=1.
- Logic ops: AND 0xF0F0F0F0 & 0x0F0F0F0F -> result=0, zero=1, carryout=0, overflow=0. OR -> 0xFFFFFFFF, zero=0. XOR 0xFFFF0000 ^ 0xFFFFFFFF -> 0x0000FFFF.
- Backpressure: stream 4 ADDs (1+1, 2+2, 3+3, 4+4) with out_ready=0 -> in_ready=0 after 2 accepted, result stays 2 and stable; raise out_ready -> results 2, 4, 6, 8 in order on consecutive cycles, none dropped.
- Sticky: overflowing ADD delivered in the same cycle as clr_sticky=1 -> ovf_sticky=1; next cycle clr_sticky=1 with no transfer -> ovf_sticky=0.
- Reset mid-stall: s1 and s2 full with out_ready=0, assert reset asynchronously -> out_valid=0 and all flags 0 immediately; after release in_ready=1 and the next op completes with 2-cycle latency. Repeat the ADD, SUB and SLT cases at WIDTH=8 (e.g. ADD 0x7F+0x01 -> 0x80, overflow=1).
